alu_pipe: RTL and testbench

Parametrised second-generation fixed-point ALU for the datapath. It executes single-cycle arithmetic and logic operations on signed Q(INT_W).(FRAC_W) operands, plus a multi-cycle iterative signed division. It keeps a bank of wide per-index accumulators and reports saturation or error through a status flag. `o_busy` is real back-pressure; upstream must hold off while a division is in flight.

---
 rtl/alu_pipe.sv | 193 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: signed fixed-point ALU with single-cycle ops, an iterative restoring
// divider that back-pressures via o_busy, and a bank of wide per-index accumulators.
module alu_pipe #(
  parameter int unsigned INST_W    = 4,
  parameter int unsigned INT_W     = 6,
  parameter int unsigned FRAC_W    = 10,
  parameter int unsigned DATA_W    = INT_W + FRAC_W,
  parameter int unsigned ACC_DEPTH = 16,
  parameter int unsigned ACC_W     = 2 * DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_busy,
  input  logic [INST_W-1:0] i_inst,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_flag
);
  localparam int unsigned IDX_W = $clog2(ACC_DEPTH);
  localparam int unsigned DIV_W = DATA_W + FRAC_W;
  localparam int unsigned CNT_W = $clog2(DIV_W + 1);
  // Wide enough to hold every pre-clamp value without overflow.
  localparam int unsigned SAT_W = ((ACC_W > DIV_W) ? ACC_W : DIV_W) + 2;

  localparam logic [INST_W-1:0] OpAdd    = INST_W'(0);
  localparam logic [INST_W-1:0] OpSub    = INST_W'(1);
  localparam logic [INST_W-1:0] OpMul    = INST_W'(2);
  localparam logic [INST_W-1:0] OpAcc    = INST_W'(3);
  localparam logic [INST_W-1:0] OpDiv    = INST_W'(4);
  localparam logic [INST_W-1:0] OpXor    = INST_W'(5);
  localparam logic [INST_W-1:0] OpAsr    = INST_W'(6);
  localparam logic [INST_W-1:0] OpRotl   = INST_W'(7);
  localparam logic [INST_W-1:0] OpClz    = INST_W'(8);
  localparam logic [INST_W-1:0] OpAccClr = INST_W'(9);

  localparam logic signed [SAT_W-1:0] MulRnd = SAT_W'(1) << (FRAC_W - 1);
  localparam logic [DATA_W:0] SatMax = {1'b1, 1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W:0] SatMin = {1'b1, 1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StDivRun} state_e;

  // Returns {flag, value}; flag set when the clamp changed the value.
  function automatic logic [DATA_W:0] sat(input logic signed [SAT_W-1:0] v);
    logic signed [SAT_W-1:0] max_v, min_v;
    max_v = {{(SAT_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    min_v = {{(SAT_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
    if (v > max_v)      return SatMax;
    else if (v < min_v) return SatMin;
    else                return {1'b0, v[DATA_W-1:0]};
  endfunction

  function automatic logic signed [SAT_W-1:0] sx(input logic [DATA_W-1:0] v);
    return {{(SAT_W - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  state_e              state_q;
  logic                busy_q, valid_q, flag_q;
  logic [DATA_W-1:0]   data_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   div_rem_q, div_den_q;
  logic [DIV_W-1:0]    div_quo_q;
  logic                div_neg_q;
  logic [ACC_W-1:0]    acc_q [ACC_DEPTH];

  logic signed [DATA_W-1:0]   a_s, b_s, asr_v;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [SAT_W-1:0]    mul_t, mul_r, acc_ext, div_val;
  logic signed [ACC_W-1:0]    acc_new;
  logic [IDX_W-1:0]           acc_idx;
  logic [31:0]                rot_amt;
  logic [DATA_W-1:0]          clz, abs_a, abs_b;
  logic [DATA_W:0]            op_res, div_res, rem_sh, rem_diff;
  logic [DATA_W-1:0]          rem_d;
  logic [DIV_W-1:0]           quo_d;
  logic                       acc_we;
  logic [ACC_W-1:0]           acc_wdata;

  // Single-cycle datapath, evaluated on the request operands.
  always_comb begin
    a_s       = i_data_a;
    b_s       = i_data_b;
    prod      = a_s * b_s;
    mul_t     = {{(SAT_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod} + MulRnd;
    mul_r     = mul_t >>> FRAC_W;
    acc_idx   = i_data_a[IDX_W-1:0];
    acc_new   = acc_q[acc_idx] + {{(ACC_W - DATA_W){i_data_b[DATA_W-1]}}, i_data_b};
    acc_ext   = {{(SAT_W - ACC_W){acc_new[ACC_W-1]}}, acc_new};
    asr_v     = a_s >>> i_data_b;
    rot_amt   = 32'(i_data_b) % DATA_W;
    clz       = DATA_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (i_data_a[i]) clz = DATA_W'(DATA_W - 1 - i);
    end
    op_res    = '0;
    acc_we    = 1'b0;
    acc_wdata = '0;
    case (i_inst)
      OpAdd:  op_res = sat(sx(i_data_a) + sx(i_data_b));
      OpSub:  op_res = sat(sx(i_data_a) - sx(i_data_b));
      OpMul:  op_res = sat(mul_r);
      OpAcc: begin
        op_res    = sat(acc_ext);
        acc_we    = 1'b1;
        acc_wdata = acc_new;
      end
      OpXor:  op_res = {1'b0, i_data_a ^ i_data_b};
      OpAsr:  op_res = (32'(i_data_b) >= DATA_W) ? {1'b0, {DATA_W{i_data_a[DATA_W-1]}}}
                                                 : {1'b0, asr_v};
      OpRotl: op_res = {1'b0, (i_data_a << rot_amt) | (i_data_a >> (DATA_W - rot_amt))};
      OpClz:  op_res = {1'b0, clz};
      OpAccClr: begin
        op_res = sat({{(SAT_W - ACC_W){acc_q[acc_idx][ACC_W-1]}}, acc_q[acc_idx]});
        acc_we = 1'b1;
      end
      OpDiv:  op_res = '0;
      default: op_res = {1'b1, {DATA_W{1'b0}}};
    endcase
  end

  // Divider operand setup and one restoring step.
  always_comb begin
    abs_a    = i_data_a[DATA_W-1] ? (~i_data_a + DATA_W'(1)) : i_data_a;
    abs_b    = i_data_b[DATA_W-1] ? (~i_data_b + DATA_W'(1)) : i_data_b;
    rem_sh   = {div_rem_q, div_quo_q[DIV_W-1]};
    rem_diff = rem_sh - {1'b0, div_den_q};
    rem_d    = rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
    quo_d    = {div_quo_q[DIV_W-2:0], ~rem_diff[DATA_W]};
    div_val  = SAT_W'(quo_d);
    if (div_neg_q) div_val = -div_val;
    div_res  = sat(div_val);
    if (div_den_q == '0) div_res = div_neg_q ? SatMin : SatMax;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      flag_q    <= 1'b0;
      cnt_q     <= '0;
      div_rem_q <= '0;
      div_den_q <= '0;
      div_quo_q <= '0;
      div_neg_q <= 1'b0;
      for (int i = 0; i < ACC_DEPTH; i++) acc_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_in_valid && (i_inst == OpDiv)) begin
            div_rem_q <= '0;
            div_quo_q <= {abs_a, {FRAC_W{1'b0}}};
            div_den_q <= abs_b;
            div_neg_q <= i_data_a[DATA_W-1] ^ i_data_b[DATA_W-1];
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StDivRun;
          end else if (i_in_valid) begin
            valid_q <= 1'b1;
            data_q  <= op_res[DATA_W-1:0];
            flag_q  <= op_res[DATA_W];
            if (acc_we) acc_q[acc_idx] <= acc_wdata;
          end
        end
        StDivRun: begin
          div_rem_q <= rem_d;
          div_quo_q <= quo_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_W - 1)) begin
            valid_q <= 1'b1;
            data_q  <= div_res[DATA_W-1:0];
            flag_q  <= div_res[DATA_W];
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_out_valid = valid_q;
  assign o_data      = data_q;
  assign o_flag      = flag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expectations; a negedge
// monitor pops and compares on every result strobe.
module tb_alu_pipe;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, ACC = 4'd3, DIV = 4'd4;
  localparam logic [3:0] XOR = 4'd5, ASR = 4'd6, ROTL = 4'd7, CLZ = 4'd8, ACLR = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        busy;
  logic [3:0]  inst = '0;
  logic [15:0] data_a = '0, data_b = '0;
  logic        out_valid;
  logic [15:0] data_o;
  logic        flag;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_d[$];
  logic        exp_f[$];
  string       exp_n[$];

  alu_pipe dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in_valid),
    .o_busy     (busy),
    .i_inst     (inst),
    .i_data_a   (data_a),
    .i_data_b   (data_b),
    .o_out_valid(out_valid),
    .o_data     (data_o),
    .o_flag     (flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor: compare each strobe against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_d.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got data %h flag %b required no strobe", data_o, flag);
      end else begin
        logic [15:0] d;
        logic        f;
        string       n;
        d = exp_d.pop_front();
        f = exp_f.pop_front();
        n = exp_n.pop_front();
        check({n, "_data"}, 32'(data_o), 32'(d));
        check({n, "_flag"}, 32'(flag), 32'(f));
      end
    end else begin
      check("idle_outputs_zero", {15'd0, flag, data_o}, 32'd0);
    end
  end

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ed, input logic ef, input string nm, input bit push);
    @(negedge clk);
    in_valid = 1'b1;
    inst     = op;
    data_a   = a;
    data_b   = b;
    if (push) begin
      exp_d.push_back(ed);
      exp_f.push_back(ef);
      exp_n.push_back(nm);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Issue a DIV, count busy cycles, and poke dropped requests while busy.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ed,
                         input logic ef, input string nm);
    int cnt;
    send(DIV, a, b, ed, ef, nm, 1'b1);
    idle();
    cnt = 0;
    while (busy && cnt < 40) begin
      in_valid = (cnt < 5);
      inst     = ADD;
      data_a   = 16'h0001;
      data_b   = 16'h0001;
      cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({nm, "_busy_cycles"}, 32'(cnt), 32'd26);
  endtask

  initial begin
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(MUL, 16'h0600, 16'h0800, 16'h0C00, 1'b0, "mul_1p5x2", 1'b1);
    send(ADD, 16'h7000, 16'h7000, 16'h7FFF, 1'b1, "add_sat", 1'b1);
    send(SUB, 16'h8000, 16'h0001, 16'h8000, 1'b1, "sub_sat", 1'b1);
    send(XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, "xor", 1'b1);
    send(MUL, 16'hFC00, 16'h0001, 16'hFFFF, 1'b0, "mul_neg", 1'b1);
    send(MUL, 16'h0001, 16'h0200, 16'h0001, 1'b0, "mul_rnd_pos", 1'b1);
    send(MUL, 16'hFFFF, 16'h0200, 16'h0000, 1'b0, "mul_rnd_neg", 1'b1);
    send(MUL, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, "mul_sat", 1'b1);
    idle();

    run_div(16'h0C00, 16'h0800, 16'h0600, 1'b0, "div_pos");
    run_div(16'hF400, 16'h0800, 16'hFA00, 1'b0, "div_neg");
    run_div(16'h0400, 16'h0000, 16'h7FFF, 1'b1, "div_zero");

    send(ACC,  16'h0004, 16'h0000, 16'h0000, 1'b0, "acc4_pre", 1'b1);
    send(ACC,  16'h0003, 16'h0400, 16'h0400, 1'b0, "acc3_a", 1'b1);
    send(ACC,  16'h0003, 16'h0400, 16'h0800, 1'b0, "acc3_b", 1'b1);
    send(ACLR, 16'h0003, 16'h0000, 16'h0800, 1'b0, "accclr3", 1'b1);
    send(ACC,  16'h0003, 16'h0001, 16'h0001, 1'b0, "acc3_after_clr", 1'b1);
    send(ACLR, 16'h0004, 16'h0000, 16'h0000, 1'b0, "accclr4", 1'b1);
    send(ACC,  16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, "acc0_p1", 1'b1);
    for (int i = 2; i <= 5; i++) send(ACC, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1, "acc0_psat", 1'b1);
    for (int i = 1; i <= 3; i++) send(ACC, 16'h0000, 16'h8000, 16'h7FFF, 1'b1, "acc0_nsat", 1'b1);
    send(ACC,  16'h0000, 16'h8000, 16'h7FFB, 1'b0, "acc0_exact", 1'b1);

    send(ROTL, 16'h8001, 16'd1,  16'h0003, 1'b0, "rotl_1", 1'b1);
    send(ROTL, 16'h8001, 16'd17, 16'h0003, 1'b0, "rotl_17", 1'b1);
    send(ASR,  16'h8000, 16'd20, 16'hFFFF, 1'b0, "asr_20", 1'b1);
    send(ASR,  16'h8000, 16'd4,  16'hF800, 1'b0, "asr_4", 1'b1);
    send(CLZ,  16'h0000, 16'h0000, 16'd16, 1'b0, "clz_zero", 1'b1);
    send(CLZ,  16'h0100, 16'h0000, 16'd7,  1'b0, "clz_0100", 1'b1);
    send(4'd12, 16'h1234, 16'h5678, 16'h0000, 1'b1, "illegal_op", 1'b1);
    idle();
    repeat (3) @(negedge clk);

    // Reset in the middle of a division: no result may appear.
    send(DIV, 16'h0C00, 16'h0800, 16'h0000, 1'b0, "div_aborted", 1'b0);
    idle();
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(data_o), 32'd0);
    check("midrst_flag", 32'(flag), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_busy_after", 32'(busy), 32'd0);
    send(ACC, 16'h0000, 16'h0001, 16'h0001, 1'b0, "acc0_after_rst", 1'b1);
    idle();

    for (int i = 0; i < 60 && exp_d.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_d.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
